// File: rtl/imem_arbiter_pkg.sv
// Shared processor constants for the instruction-memory arbiter:
// memory depth default, word-index width helper, illegal-fetch filler word
// and the grant-select encoding used between the arbiter blocks.
package imem_arbiter_pkg;

   localparam int unsigned SIZE_IM_DEF  = 128;
   localparam logic [31:0] FETCH_FILLER = 32'h0000_0000;

   typedef enum logic [1:0] {
      SEL_NONE  = 2'b00,
      SEL_FETCH = 2'b01,
      SEL_LOAD  = 2'b10
   } sel_e;

   // Width of an index into a table of 'size' entries, never below one bit.
   function automatic int unsigned idx_width(input int unsigned size);
      return (size > 32'd1) ? int'($clog2(size)) : 32'd1;
   endfunction

   // A byte address is usable only when word aligned and inside the memory.
   function automatic logic addr_legal(input logic [31:0] addr, input int unsigned size);
      return (addr[1:0] == 2'b00) && ((addr >> 2) < size);
   endfunction

   localparam int unsigned IDX_W_DEF = idx_width(SIZE_IM_DEF);

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch port, loader port and memory port of the arbiter.
// slave: seen from the arbiter; master: seen from requesters and memory.
interface imem_arbiter_if
   import imem_arbiter_pkg::*;
#(
   parameter int unsigned SIZE_IM = SIZE_IM_DEF
) ();

   localparam int unsigned IDX_W = idx_width(SIZE_IM);

   logic             fetch_req;
   logic [31:0]      fetch_addr;
   logic             fetch_gnt;
   logic             fetch_valid;
   logic [31:0]      fetch_instru;
   logic             load_req;
   logic [31:0]      load_addr;
   logic [31:0]      load_data;
   logic             load_gnt;
   logic             mem_we;
   logic [IDX_W-1:0] mem_addr;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;
   logic             addr_err;

   modport slave (
      input  fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
      output fetch_gnt, fetch_valid, fetch_instru, load_gnt,
             mem_we, mem_addr, mem_wdata, addr_err
   );

   modport master (
      output fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
      input  fetch_gnt, fetch_valid, fetch_instru, load_gnt,
             mem_we, mem_addr, mem_wdata, addr_err
   );

endinterface

// File: rtl/imem_arb_prio.sv
// Priority and starvation control: the loader wins contention until the
// fetch side has waited STARVE_MAX consecutive loader grants.
module imem_arb_prio
   import imem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   localparam int unsigned CNT_W = idx_width(STARVE_MAX + 32'd1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic fetch_req_i,
   input  logic load_req_i,
   output sel_e sel_o
);

   logic [CNT_W-1:0] starve_cnt_q;
   logic [CNT_W-1:0] starve_cnt_d;
   logic             starved_s;

   assign starved_s = (starve_cnt_q == CNT_W'(STARVE_MAX));

   // Grant selection and next starvation count; nothing is granted in reset.
   always_comb begin
      sel_o        = SEL_NONE;
      starve_cnt_d = starve_cnt_q;
      if (!rst_n) begin
         sel_o = SEL_NONE;
      end else if (load_req_i && !(fetch_req_i && starved_s)) begin
         sel_o = SEL_LOAD;
      end else if (fetch_req_i) begin
         sel_o = SEL_FETCH;
      end else begin
         sel_o = SEL_NONE;
      end

      if (!fetch_req_i || (sel_o == SEL_FETCH)) begin
         starve_cnt_d = {CNT_W{1'b0}};
      end else if ((sel_o == SEL_LOAD) && !starved_s) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= {CNT_W{1'b0}};
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port memory between the
// instruction fetch path and a program loader, with address checking and a
// one-cycle registered fetch result.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int unsigned SIZE_IM    = SIZE_IM_DEF,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic          clk,
   input logic          rst_n,
   imem_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = idx_width(SIZE_IM);

   sel_e             sel_s;
   logic             fetch_legal_s;
   logic             load_legal_s;
   logic [IDX_W-1:0] mem_addr_s;
   logic             err_s;
   logic             fetch_valid_q;
   logic             fetch_valid_d;
   logic [31:0]      fetch_instru_q;
   logic [31:0]      fetch_instru_d;
   logic             addr_err_q;

   imem_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_req_i (bus.fetch_req),
      .load_req_i  (bus.load_req),
      .sel_o       (sel_s)
   );

   assign fetch_legal_s = addr_legal(bus.fetch_addr, SIZE_IM);
   assign load_legal_s  = addr_legal(bus.load_addr, SIZE_IM);

   // Memory address mux and error detect for whichever side holds the grant.
   always_comb begin
      mem_addr_s = {IDX_W{1'b0}};
      err_s      = 1'b0;
      case (sel_s)
         SEL_FETCH: begin
            mem_addr_s = bus.fetch_addr[IDX_W+1:2];
            err_s      = !fetch_legal_s;
         end
         SEL_LOAD: begin
            mem_addr_s = bus.load_addr[IDX_W+1:2];
            err_s      = !load_legal_s;
         end
         default: begin
            mem_addr_s = {IDX_W{1'b0}};
            err_s      = 1'b0;
         end
      endcase
   end

   // Next fetch result: memory word for a legal fetch, filler for an illegal one.
   always_comb begin
      fetch_valid_d  = 1'b0;
      fetch_instru_d = fetch_instru_q;
      if (sel_s == SEL_FETCH) begin
         fetch_valid_d  = 1'b1;
         fetch_instru_d = fetch_legal_s ? bus.mem_rdata : FETCH_FILLER;
      end else begin
         fetch_valid_d  = 1'b0;
         fetch_instru_d = fetch_instru_q;
      end
   end

   // Result registers; reset discards any fetch still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_valid_q  <= 1'b0;
         fetch_instru_q <= 32'h0000_0000;
         addr_err_q     <= 1'b0;
      end else begin
         fetch_valid_q  <= fetch_valid_d;
         fetch_instru_q <= fetch_instru_d;
         addr_err_q     <= err_s;
      end
   end

   assign bus.fetch_gnt    = (sel_s == SEL_FETCH);
   assign bus.load_gnt     = (sel_s == SEL_LOAD);
   assign bus.mem_we       = (sel_s == SEL_LOAD) && load_legal_s;
   assign bus.mem_addr     = mem_addr_s;
   assign bus.mem_wdata    = bus.load_data;
   assign bus.fetch_valid  = fetch_valid_q;
   assign bus.fetch_instru = fetch_instru_q;
   assign bus.addr_err     = addr_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter: a driver issues one request set per
// cycle and queues the response it expects; a monitor compares each response
// the arbiter presents against the queue head.
module tb_imem_arbiter;

   typedef struct {
      bit          is_fetch;
      logic [31:0] instru;
      bit          err;
   } exp_t;

   logic clk;
   logic rst_n;
   logic [31:0] mem [0:127];
   exp_t exp_q [$];
   int pass_cnt;
   int total_cnt;

   imem_arbiter_if #(.SIZE_IM(128)) bus ();

   imem_arbiter #(
      .SIZE_IM    (128),
      .STARVE_MAX (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational read, write on the rising edge.
   assign bus.mem_rdata = mem[bus.mem_addr];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every response the arbiter presents must match the queue head.
   always @(negedge clk) begin
      if (bus.fetch_valid || bus.addr_err) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL spurious_rsp: valid=%0b err=%0b instru=0x%08h, expected no response at %0t",
                     bus.fetch_valid, bus.addr_err, bus.fetch_instru, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_valid", {31'b0, bus.fetch_valid}, {31'b0, e.is_fetch});
            check("rsp_err", {31'b0, bus.addr_err}, {31'b0, e.err});
            if (e.is_fetch) check("rsp_instru", bus.fetch_instru, e.instru);
         end
      end
   end

   // One request cycle: drive, check the combinational grant side, queue the response.
   task automatic drive(input bit fr, input logic [31:0] fa,
                        input bit lr, input logic [31:0] la, input logic [31:0] ld,
                        input bit efg, input bit elg, input logic [31:0] einstr,
                        input bit eerr, input bit push);
      logic [31:0] a;
      exp_t e;
      @(posedge clk);
      #1;
      bus.fetch_req  = fr;
      bus.fetch_addr = fa;
      bus.load_req   = lr;
      bus.load_addr  = la;
      bus.load_data  = ld;
      #1;
      a = elg ? la : (efg ? fa : 32'h0000_0000);
      check("fetch_gnt", {31'b0, bus.fetch_gnt}, {31'b0, efg});
      check("load_gnt", {31'b0, bus.load_gnt}, {31'b0, elg});
      check("mem_we", {31'b0, bus.mem_we}, {31'b0, elg && !eerr});
      check("mem_addr", {25'b0, bus.mem_addr}, {25'b0, a[8:2]});
      if (bus.mem_we) check("mem_wdata", bus.mem_wdata, ld);
      check("starve_bound", {31'b0, (dut.u_prio.starve_cnt_q <= 3'd4)}, 32'd1);
      if (push && efg) begin
         e.is_fetch = 1'b1; e.instru = einstr; e.err = eerr;
         exp_q.push_back(e);
      end
      if (push && elg && eerr) begin
         e.is_fetch = 1'b0; e.instru = 32'h0000_0000; e.err = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0000;
      mem[2] = 32'h2010_0005;

      // Reset with both requesters active: nothing granted, outputs cleared.
      rst_n          = 1'b0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0008;
      bus.load_req   = 1'b1;
      bus.load_addr  = 32'h0000_0040;
      bus.load_data  = 32'h0000_0000;
      #2;
      check("rst_fetch_gnt", {31'b0, bus.fetch_gnt}, 32'd0);
      check("rst_load_gnt", {31'b0, bus.load_gnt}, 32'd0);
      check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
      check("rst_valid", {31'b0, bus.fetch_valid}, 32'd0);
      check("rst_instru", bus.fetch_instru, 32'h0000_0000);
      check("rst_err", {31'b0, bus.addr_err}, 32'd0);
      #6;
      check("rst_valid_clk", {31'b0, bus.fetch_valid}, 32'd0);
      check("rst_starve", {29'b0, dut.u_prio.starve_cnt_q}, 32'd0);
      bus.fetch_req = 1'b0;
      bus.load_req  = 1'b0;
      #4 rst_n = 1'b1;

      // Basic fetch, load to the top word, read-back, back-to-back fetch.
      drive(1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h2010_0005, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 1'b1, 32'h0000_01FC, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      check("load_top_idx", {25'b0, bus.mem_addr}, 32'd127);
      drive(1'b1, 32'h0000_01FC, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      drive(1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h2010_0005, 1'b0, 1'b1);
      idle();
      idle();
      @(negedge clk);
      check("idle_valid", {31'b0, bus.fetch_valid}, 32'd0);
      check("instru_hold", bus.fetch_instru, 32'h2010_0005);

      // Contention: loader wins four times, then the waiting fetch gets through.
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 32'h0000_0008, 1'b1, 32'h0000_0040, 32'hA000_0000 + i,
               (i == 4), (i != 4), 32'h2010_0005, 1'b0, 1'b1);
      end
      idle();

      // Illegal accesses: misaligned and out-of-range on both sides.
      drive(1'b1, 32'h0000_0006, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 1'b1, 32'h0000_0200, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
      drive(1'b1, 32'h0000_0200, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 1'b1, 32'h0000_0041, 32'h5555_AAAA, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
      drive(1'b1, 32'h0000_0040, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hA000_0008, 1'b0, 1'b1);
      idle();
      idle();

      // Reset while fetch results are in flight: both are discarded.
      drive(1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 32'h0000_01FC, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'b0, bus.fetch_valid}, 32'd0);
      check("mid_rst_instru", bus.fetch_instru, 32'h0000_0000);
      check("mid_rst_err", {31'b0, bus.addr_err}, 32'd0);
      check("mid_rst_fetch_gnt", {31'b0, bus.fetch_gnt}, 32'd0);
      check("mid_rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
      check("mid_rst_starve", {29'b0, dut.u_prio.starve_cnt_q}, 32'd0);
      bus.fetch_req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_valid", {31'b0, bus.fetch_valid}, 32'd0);
      check("post_rst_instru", bus.fetch_instru, 32'h0000_0000);
      idle();
      @(negedge clk);
      check("post_rst_valid2", {31'b0, bus.fetch_valid}, 32'd0);
      idle();
      idle();
      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
